// File: rtl/branch_resolve_id.sv
// branch_resolve_id: IF/ID register with decode-stage beq/bne/j resolution and wrong-path squash
module branch_resolve_id #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_instruction,
    input  logic [31:0]      if_pc_plus1,
    input  logic             stall,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rt_addr,
    output logic             pc_src,
    output logic [31:0]      branch_addr,
    output logic             pc_hold,
    output logic [31:0]      id_instruction,
    output logic [31:0]      id_pc_plus1,
    output logic             id_valid,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state;
    logic [2:0] flush_cnt;
    logic [5:0] op;
    logic is_beq, is_bne, is_j, taken, run;
    logic [31:0] target;
    assign op = id_instruction[31:26];
    assign is_beq = op == 6'h04;
    assign is_bne = op == 6'h05;
    assign is_j = op == 6'h02;
    assign run = state == RUN;
    assign rs_addr = id_instruction[25:21];
    assign rt_addr = id_instruction[20:16];
    assign taken = id_valid & ((is_beq & rs_data == rt_data) | (is_bne & rs_data != rt_data) | is_j);
    assign target = is_j ? {id_pc_plus1[31:26], id_instruction[25:0]}
                         : id_pc_plus1 + {{16{id_instruction[15]}}, id_instruction[15:0]};
    assign pc_src = taken & run & !stall;
    assign branch_addr = (is_beq | is_bne | is_j) ? target : '0;
    assign pc_hold = stall & run;
    // Bubbles keep the old PC+1; only the instruction and valid bit are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            flush_cnt <= '0;
            id_instruction <= '0;
            id_pc_plus1 <= '0;
            id_valid <= 1'b0;
            branch_cnt <= '0;
            taken_cnt <= '0;
        end else if (state == FLUSH) begin
            id_instruction <= '0;
            id_valid <= 1'b0;
            flush_cnt <= flush_cnt - 3'd1;
            if (flush_cnt == 3'd1) state <= RUN;
        end else if (!stall) begin
            if (pc_src) begin
                id_instruction <= '0;
                id_valid <= 1'b0;
                branch_cnt <= branch_cnt + CNT_W'(1);
                taken_cnt <= taken_cnt + CNT_W'(1);
                flush_cnt <= 3'(FLUSH_CYCLES);
                state <= FLUSH;
            end else begin
                id_instruction <= if_instruction;
                id_pc_plus1 <= if_pc_plus1;
                id_valid <= 1'b1;
                if (id_valid & (is_beq | is_bne)) branch_cnt <= branch_cnt + CNT_W'(1);
            end
        end
    end
endmodule
